// File: rtl/x86_add_decoder_pkg.sv
// Shared definitions for the byte-serial ADD/MOV/far-JMP decoder.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package x86_add_decoder_pkg;

  // Supported opcodes
  localparam logic [7:0] OPC_ADD_RM_R   = 8'h01;
  localparam logic [7:0] OPC_ADD_R_RM   = 8'h03;
  localparam logic [7:0] OPC_GRP1_IMM32 = 8'h81;
  localparam logic [7:0] OPC_GRP1_IMM8  = 8'h83;
  localparam logic [7:0] OPC_MOV_R_IMM  = 8'hB8;  // B8+r, register in [2:0]
  localparam logic [7:0] OPC_JMP_FAR    = 8'hEA;

  // Datapath operation codes
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_MOV = 2'd2;

  // Immediate size encodings
  localparam logic [1:0] IMMSZ_NONE = 2'd0;
  localparam logic [1:0] IMMSZ_8    = 2'd1;
  localparam logic [1:0] IMMSZ_32   = 2'd2;
  localparam logic [1:0] IMMSZ_48   = 2'd3;

  // Displacement size encodings
  localparam logic [1:0] DISPSZ_8    = 2'd0;
  localparam logic [1:0] DISPSZ_32   = 2'd1;
  localparam logic [1:0] DISPSZ_NONE = 2'd2;

  typedef enum logic [2:0] {
    ST_OPC,
    ST_MODRM,
    ST_DISP,
    ST_IMM,
    ST_EMIT
  } state_e;

  // Control fields of the decoded bundle (immediate and displacement
  // live in separately parameterised registers in the top).
  typedef struct packed {
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic       isAddrbd;
    logic       o1m;
    logic       o2m;
    logic [1:0] immSize;
    logic [1:0] disp_size;
    logic [1:0] op;
    logic       far_jmp;
    logic [3:0] len;
  } ctl_t;

  function automatic ctl_t ctl_rst();
    ctl_t c;
    c           = '0;
    c.disp_size = DISPSZ_NONE;
    return c;
  endfunction

  // Number of immediate bytes to collect for a given size code.
  function automatic logic [2:0] imm_bytes(input logic [1:0] sz);
    case (sz)
      IMMSZ_8:  return 3'd1;
      IMMSZ_32: return 3'd4;
      IMMSZ_48: return 3'd6;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/x86_modrm_decode.sv
// ModRM byte splitter: fields, addressing mode, memory flag, SIB detection.
// Latency: combinational.
// Backpressure: none (pure function of the input byte).
// Ports: modrm in; mod/reg_op/rm fields, disp_size code, isAddrbd
//        (mod=00 rm=101 absolute disp32), mem (mod!=11), sib_err (SIB form).
module x86_modrm_decode
  import x86_add_decoder_pkg::*;
(
  input  logic [7:0] modrm,
  output logic [1:0] mod,
  output logic [2:0] reg_op,
  output logic [2:0] rm,
  output logic [1:0] disp_size,
  output logic       isAddrbd,
  output logic       mem,
  output logic       sib_err
);

  assign mod      = modrm[7:6];
  assign reg_op   = modrm[5:3];
  assign rm       = modrm[2:0];
  assign mem      = (mod != 2'b11);
  assign isAddrbd = (mod == 2'b00) && (rm == 3'b101);
  // rm=100 in any memory form needs a SIB byte, which this decoder lacks.
  assign sib_err  = mem && (rm == 3'b100);

  always_comb begin
    disp_size = DISPSZ_NONE;
    case (mod)
      2'b00:   disp_size = isAddrbd ? DISPSZ_32 : DISPSZ_NONE;
      2'b01:   disp_size = DISPSZ_8;
      2'b10:   disp_size = DISPSZ_32;
      default: disp_size = DISPSZ_NONE;
    endcase
  end

endmodule

// File: rtl/x86_add_decoder.sv
// Byte-serial x86 ADD/MOV/far-JMP decoder producing a decoded-field bundle.
// Latency: o_valid rises the cycle after the last instruction byte is accepted.
// Backpressure: in_ready drops while a bundle waits in EMIT; held until o_ready.
// Ports: clk/rst (sync, active-high); in_valid/in_byte/in_ready byte stream;
//        o_valid/o_ready bundle handshake; o_* decoded fields, o_len, o_err pulse.
module x86_add_decoder
  import x86_add_decoder_pkg::*;
#(
  parameter int IMM_W  = 48,
  parameter int DISP_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [2:0]        o_sr1,
  output logic [2:0]        o_sr2,
  output logic              o_isAddrbd,
  output logic              o_isO1Mem,
  output logic              o_isO2Mem,
  output logic [1:0]        o_immSize,
  output logic [IMM_W-1:0]  o_imm,
  output logic [DISP_W-1:0] o_disp,
  output logic [1:0]        o_disp_size,
  output logic [1:0]        o_op,
  output logic              o_far_jmp,
  output logic [3:0]        o_len,
  output logic              o_err
);

  state_e              state_q, state_d;
  ctl_t                ctl_q, ctl_d;
  logic [IMM_W-1:0]    imm_q, imm_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic [7:0]          opc_q, opc_d;
  logic [2:0]          cnt_q, cnt_d;   // bytes still to collect in DISP/IMM
  logic [2:0]          pos_q, pos_d;   // byte lane for the next field byte
  logic                err_q, err_d;

  logic                accept;
  logic                grp1;
  logic [1:0]          imm_sz;

  logic [1:0]          md_mod;
  logic [2:0]          md_reg;
  logic [2:0]          md_rm;
  logic [1:0]          md_disp_size;
  logic                md_isAddrbd;
  logic                md_mem;
  logic                md_sib_err;

  x86_modrm_decode u_modrm (
    .modrm     (in_byte),
    .mod       (md_mod),
    .reg_op    (md_reg),
    .rm        (md_rm),
    .disp_size (md_disp_size),
    .isAddrbd  (md_isAddrbd),
    .mem       (md_mem),
    .sib_err   (md_sib_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OPC;
      ctl_q   <= ctl_rst();
      imm_q   <= '0;
      disp_q  <= '0;
      opc_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      imm_q   <= imm_d;
      disp_q  <= disp_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctl_d    = ctl_q;
    imm_d    = imm_q;
    disp_d   = disp_q;
    opc_d    = opc_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    err_d    = 1'b0;
    imm_sz   = IMMSZ_NONE;
    in_ready = (state_q != ST_EMIT);
    accept   = in_valid && in_ready;
    grp1     = (opc_q == OPC_GRP1_IMM32) || (opc_q == OPC_GRP1_IMM8);

    case (state_q)
      ST_OPC: begin
        if (accept) begin
          ctl_d     = ctl_rst();
          imm_d     = '0;
          disp_d    = '0;
          opc_d     = in_byte;
          cnt_d     = 3'd0;
          pos_d     = 3'd0;
          ctl_d.len = 4'd1;
          if ((in_byte == OPC_ADD_RM_R) || (in_byte == OPC_ADD_R_RM) ||
              (in_byte == OPC_GRP1_IMM32) || (in_byte == OPC_GRP1_IMM8)) begin
            state_d = ST_MODRM;
          end else if (in_byte[7:3] == OPC_MOV_R_IMM[7:3]) begin
            ctl_d.sr1     = in_byte[2:0];
            ctl_d.sr2     = in_byte[2:0];
            ctl_d.op      = OP_MOV;
            ctl_d.immSize = IMMSZ_32;
            cnt_d         = imm_bytes(IMMSZ_32);
            state_d       = ST_IMM;
          end else if (in_byte == OPC_JMP_FAR) begin
            ctl_d.far_jmp = 1'b1;
            ctl_d.immSize = IMMSZ_48;
            cnt_d         = imm_bytes(IMMSZ_48);
            state_d       = ST_IMM;
          end else begin
            ctl_d = ctl_rst();
            err_d = 1'b1;
          end
        end
      end

      ST_MODRM: begin
        if (accept) begin
          ctl_d.len = ctl_q.len + 4'd1;
          // Group 1 with reg!=0 is OR/ADC/SUB/..., which the datapath lacks.
          if (md_sib_err || (grp1 && (md_reg != 3'd0))) begin
            ctl_d   = ctl_rst();
            err_d   = 1'b1;
            state_d = ST_OPC;
          end else begin
            ctl_d.op        = OP_ADD;
            ctl_d.isAddrbd  = md_isAddrbd;
            ctl_d.disp_size = md_disp_size;
            case (opc_q)
              OPC_ADD_RM_R: begin
                ctl_d.sr1 = md_rm;
                ctl_d.sr2 = md_reg;
                ctl_d.o1m = md_mem;
              end
              OPC_ADD_R_RM: begin
                ctl_d.sr1 = md_reg;
                ctl_d.sr2 = md_rm;
                ctl_d.o2m = md_mem;
              end
              default: begin
                ctl_d.sr1 = md_rm;
                ctl_d.sr2 = md_rm;
                ctl_d.o1m = md_mem;
              end
            endcase
            if (opc_q == OPC_GRP1_IMM32) begin
              imm_sz = IMMSZ_32;
            end else if (opc_q == OPC_GRP1_IMM8) begin
              imm_sz = IMMSZ_8;
            end
            ctl_d.immSize = imm_sz;
            pos_d         = 3'd0;
            if (md_disp_size != DISPSZ_NONE) begin
              state_d = ST_DISP;
              cnt_d   = (md_mod == 2'b01) ? 3'd1 : 3'd4;
            end else if (imm_sz != IMMSZ_NONE) begin
              state_d = ST_IMM;
              cnt_d   = imm_bytes(imm_sz);
            end else begin
              state_d = ST_EMIT;
            end
          end
        end
      end

      ST_DISP: begin
        if (accept) begin
          ctl_d.len = ctl_q.len + 4'd1;
          for (int i = 0; i < DISP_W / 8; i++) begin
            if (pos_q == 3'(i)) disp_d[8*i +: 8] = in_byte;
          end
          if (cnt_q == 3'd1) begin
            pos_d = 3'd0;
            if (ctl_q.immSize != IMMSZ_NONE) begin
              state_d = ST_IMM;
              cnt_d   = imm_bytes(ctl_q.immSize);
            end else begin
              state_d = ST_EMIT;
            end
          end else begin
            cnt_d = cnt_q - 3'd1;
            pos_d = pos_q + 3'd1;
          end
        end
      end

      ST_IMM: begin
        if (accept) begin
          ctl_d.len = ctl_q.len + 4'd1;
          for (int i = 0; i < IMM_W / 8; i++) begin
            if (pos_q == 3'(i)) imm_d[8*i +: 8] = in_byte;
          end
          if (cnt_q == 3'd1) begin
            pos_d   = 3'd0;
            state_d = ST_EMIT;
          end else begin
            cnt_d = cnt_q - 3'd1;
            pos_d = pos_q + 3'd1;
          end
        end
      end

      ST_EMIT: begin
        if (o_ready) begin
          ctl_d   = ctl_rst();
          imm_d   = '0;
          disp_d  = '0;
          state_d = ST_OPC;
        end
      end

      default: begin
        state_d = ST_OPC;
      end
    endcase
  end

  assign o_valid     = (state_q == ST_EMIT);
  assign o_sr1       = ctl_q.sr1;
  assign o_sr2       = ctl_q.sr2;
  assign o_isAddrbd  = ctl_q.isAddrbd;
  assign o_isO1Mem   = ctl_q.o1m;
  assign o_isO2Mem   = ctl_q.o2m;
  assign o_immSize   = ctl_q.immSize;
  assign o_imm       = imm_q;
  assign o_disp      = disp_q;
  assign o_disp_size = ctl_q.disp_size;
  assign o_op        = ctl_q.op;
  assign o_far_jmp   = ctl_q.far_jmp;
  assign o_len       = ctl_q.len;
  assign o_err       = err_q;

endmodule

// File: tb/tb_x86_add_decoder.sv
// Self-checking bench for x86_add_decoder: directed table, corner sequences,
// and randomized instructions checked against a whole-instruction decoder.
module tb_x86_add_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        o_valid;
  logic        o_ready;
  logic [2:0]  o_sr1;
  logic [2:0]  o_sr2;
  logic        o_isAddrbd;
  logic        o_isO1Mem;
  logic        o_isO2Mem;
  logic [1:0]  o_immSize;
  logic [47:0] o_imm;
  logic [31:0] o_disp;
  logic [1:0]  o_disp_size;
  logic [1:0]  o_op;
  logic        o_far_jmp;
  logic [3:0]  o_len;
  logic        o_err;

  x86_add_decoder #(.IMM_W(48), .DISP_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_sr1(o_sr1), .o_sr2(o_sr2), .o_isAddrbd(o_isAddrbd),
    .o_isO1Mem(o_isO1Mem), .o_isO2Mem(o_isO2Mem),
    .o_immSize(o_immSize), .o_imm(o_imm), .o_disp(o_disp),
    .o_disp_size(o_disp_size), .o_op(o_op), .o_far_jmp(o_far_jmp),
    .o_len(o_len), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        isAddrbd;
    logic        o1m;
    logic        o2m;
    logic [1:0]  immSize;
    logic [47:0] imm;
    logic [31:0] disp;
    logic [1:0]  disp_size;
    logic [1:0]  op;
    logic        far_jmp;
    logic [3:0]  len;
  } res_t;

  // bytes: instruction written in reading order, first byte most significant
  typedef struct {
    logic [79:0] bytes;
    logic [3:0]  n;
    logic        err;
    res_t        exp;
  } vec_t;

  int   n_checks;
  int   n_fail;
  vec_t vecs[10];
  res_t rst_res;

  function automatic res_t mk(input logic [2:0] s1, input logic [2:0] s2,
                              input logic ab, input logic m1, input logic m2,
                              input logic [1:0] isz, input logic [47:0] imm,
                              input logic [31:0] dsp, input logic [1:0] ds,
                              input logic [1:0] op, input logic fj,
                              input logic [3:0] ln);
    res_t r;
    r.sr1 = s1; r.sr2 = s2; r.isAddrbd = ab; r.o1m = m1; r.o2m = m2;
    r.immSize = isz; r.imm = imm; r.disp = dsp; r.disp_size = ds;
    r.op = op; r.far_jmp = fj; r.len = ln;
    return r;
  endfunction

  function automatic res_t capture();
    res_t r;
    r.sr1 = o_sr1; r.sr2 = o_sr2; r.isAddrbd = o_isAddrbd;
    r.o1m = o_isO1Mem; r.o2m = o_isO2Mem; r.immSize = o_immSize;
    r.imm = o_imm; r.disp = o_disp; r.disp_size = o_disp_size;
    r.op = o_op; r.far_jmp = o_far_jmp; r.len = o_len;
    return r;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("sr1=%0d sr2=%0d abs=%0d o1m=%0d o2m=%0d isz=%0d imm=%h disp=%h ds=%0d op=%0d fj=%0d len=%0d",
                     r.sr1, r.sr2, r.isAddrbd, r.o1m, r.o2m, r.immSize, r.imm,
                     r.disp, r.disp_size, r.op, r.far_jmp, r.len);
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_res(input string name, input res_t act, input res_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got [%s] expected [%s]", name, fmt(act), fmt(exp));
    end
  endtask

  // Called at a negedge; returns at the negedge just after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [79:0] sh;
    o_ready = 1'b1;
    for (int i = 0; i < int'(v.n); i++) begin
      if (i == int'(v.n) - 1 && i > 0) check1({nm, ".early_valid"}, o_valid, 1'b0);
      sh = v.bytes >> (8 * (int'(v.n) - 1 - i));
      send_byte(sh[7:0], 0);
    end
    if (v.err) begin
      check1({nm, ".err"}, o_err, 1'b1);
      check1({nm, ".no_valid"}, o_valid, 1'b0);
      @(negedge clk);
      check1({nm, ".err_pulse"}, o_err, 1'b0);
    end else begin
      check1({nm, ".valid"}, o_valid, 1'b1);
      check1({nm, ".no_err"}, o_err, 1'b0);
      check_res({nm, ".fields"}, capture(), v.exp);
      @(negedge clk);
      check1({nm, ".valid_drop"}, o_valid, 1'b0);
      check1({nm, ".cleared"}, (o_disp_size == 2'd2) && (o_len == 4'd0), 1'b1);
    end
  endtask

  // Little-endian value of c bytes starting at byte s (byte 0 in bb[7:0]).
  function automatic logic [63:0] le(input logic [79:0] bb, input int s, input int c);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < c; k++)
      v = v | ((64'(bb >> (8 * (s + k))) & 64'hFF) << (8 * k));
    return v;
  endfunction

  // Decodes a whole instruction at once from its byte string.
  function automatic void model(input logic [79:0] bb, output res_t r,
                                output int n, output bit er);
    int op, m, md, rg, rm, dl, il;
    r = '0;
    r.disp_size = 2'd2;
    er = 1'b0;
    n  = 1;
    op = int'(bb[7:0]);
    if (op >= 'hB8 && op <= 'hBF) begin
      r.sr1 = 3'(op - 'hB8); r.sr2 = 3'(op - 'hB8);
      r.op = 2'd2; r.immSize = 2'd2; r.imm = 48'(le(bb, 1, 4)); n = 5;
    end else if (op == 'hEA) begin
      r.far_jmp = 1'b1; r.immSize = 2'd3; r.imm = 48'(le(bb, 1, 6)); n = 7;
    end else if (op == 'h01 || op == 'h03 || op == 'h81 || op == 'h83) begin
      m  = int'(bb[15:8]);
      md = m / 64; rg = (m / 8) % 8; rm = m % 8;
      n  = 2;
      if ((md != 3 && rm == 4) || (op >= 'h80 && rg != 0)) begin
        er = 1'b1;
      end else begin
        dl = (md == 1) ? 1 : ((md == 2) || (md == 0 && rm == 5)) ? 4 : 0;
        il = (op == 'h81) ? 4 : (op == 'h83) ? 1 : 0;
        r.disp      = 32'(le(bb, 2, dl));
        r.imm       = 48'(le(bb, 2 + dl, il));
        r.disp_size = (dl == 0) ? 2'd2 : (dl == 1) ? 2'd0 : 2'd1;
        r.immSize   = (il == 0) ? 2'd0 : (il == 1) ? 2'd1 : 2'd2;
        r.isAddrbd  = (md == 0 && rm == 5);
        if (op == 'h01) begin
          r.sr1 = 3'(rm); r.sr2 = 3'(rg); r.o1m = (md != 3);
        end else if (op == 'h03) begin
          r.sr1 = 3'(rg); r.sr2 = 3'(rm); r.o2m = (md != 3);
        end else begin
          r.sr1 = 3'(rm); r.sr2 = 3'(rm); r.o1m = (md != 3);
        end
        n = 2 + dl + il;
      end
    end else begin
      er = 1'b1;
    end
    if (!er) r.len = 4'(n);
  endfunction

  initial begin
    logic [79:0] bb;
    logic [79:0] sh;
    res_t        e;
    int          n;
    bit          er;
    int          stall;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    o_ready  = 1'b0;
    rst_res  = mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 48'h0, 32'h0, 2'd2, 2'd0, 1'b0, 4'd0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_res("reset.fields", capture(), rst_res);
    check1("reset.valid", o_valid, 1'b0);
    check1("reset.in_ready", in_ready, 1'b1);
    check1("reset.err", o_err, 1'b0);

    vecs[0] = '{80'hBB78563412, 4'd5, 1'b0,
                mk(3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 2'd2, 48'h12345678, 32'h0, 2'd2, 2'd2, 1'b0, 4'd5)};
    vecs[1] = '{80'h810520_00AB89A0008FF8, 4'd10, 1'b0,
                mk(3'd5, 3'd5, 1'b1, 1'b1, 1'b0, 2'd2, 48'hF88F00A0, 32'h89AB0020, 2'd1, 2'd0, 1'b0, 4'd10)};
    vecs[2] = '{80'h83468005, 4'd4, 1'b0,
                mk(3'd6, 3'd6, 1'b0, 1'b1, 1'b0, 2'd1, 48'h05, 32'h80, 2'd0, 2'd0, 1'b0, 4'd4)};
    vecs[3] = '{80'h033E, 4'd2, 1'b0,
                mk(3'd7, 3'd6, 1'b0, 1'b0, 1'b1, 2'd0, 48'h0, 32'h0, 2'd2, 2'd0, 1'b0, 4'd2)};
    vecs[4] = '{80'h01D1, 4'd2, 1'b0,
                mk(3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 48'h0, 32'h0, 2'd2, 2'd0, 1'b0, 4'd2)};
    vecs[5] = '{80'h018044332211, 4'd6, 1'b0,
                mk(3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 2'd0, 48'h0, 32'h11223344, 2'd1, 2'd0, 1'b0, 4'd6)};
    vecs[6] = '{80'h83C07F, 4'd3, 1'b0,
                mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1, 48'h7F, 32'h0, 2'd2, 2'd0, 1'b0, 4'd3)};
    vecs[7] = '{80'h0F, 4'd1, 1'b1, rst_res};
    vecs[8] = '{80'h0104, 4'd2, 1'b1, rst_res};
    vecs[9] = '{80'h81C8, 4'd2, 1'b1, rst_res};

    for (int k = 0; k < 10; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Far jump held in EMIT for three cycles with a byte offered meanwhile
    o_ready = 1'b0;
    bb = 80'hEA78563412_8FF8;
    for (int i = 0; i < 7; i++) begin
      sh = bb >> (8 * (6 - i));
      send_byte(sh[7:0], 0);
    end
    e = mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd3, 48'hF88F12345678, 32'h0, 2'd2, 2'd0, 1'b1, 4'd7);
    check1("stall.valid", o_valid, 1'b1);
    check_res("stall.fields", capture(), e);
    in_valid = 1'b1;
    in_byte  = 8'h01;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check1($sformatf("stall.hold_valid%0d", c), o_valid, 1'b1);
      check1($sformatf("stall.in_ready%0d", c), in_ready, 1'b0);
      check_res($sformatf("stall.hold_fields%0d", c), capture(), e);
    end
    in_valid = 1'b0;
    o_ready  = 1'b1;
    @(negedge clk);
    check1("stall.release_valid", o_valid, 1'b0);
    check1("stall.release_in_ready", in_ready, 1'b1);

    // Errors, then reset in the middle of a partial 81 05 20
    run_vec(vecs[7], "rst_seq.err0F");
    run_vec(vecs[8], "rst_seq.errSIB");
    send_byte(8'h81, 0);
    send_byte(8'h05, 0);
    send_byte(8'h20, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_res("rst_mid.fields", capture(), rst_res);
    check1("rst_mid.valid", o_valid, 1'b0);
    check1("rst_mid.in_ready", in_ready, 1'b1);
    check1("rst_mid.err", o_err, 1'b0);
    run_vec(vecs[0], "rst_mid.after");

    // Reset while a bundle is stalled in EMIT
    o_ready = 1'b0;
    send_byte(8'h03, 0);
    send_byte(8'h3E, 0);
    check1("rst_emit.valid_before", o_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check1("rst_emit.valid", o_valid, 1'b0);
    check1("rst_emit.in_ready", in_ready, 1'b1);
    check_res("rst_emit.fields", capture(), rst_res);

    // Random instructions with input gaps and output stalls
    for (int k = 0; k < 300; k++) begin
      for (int j = 0; j < 10; j++) bb = {bb[71:0], 8'($urandom)};
      case ($urandom_range(0, 6))
        0: bb[7:0] = 8'h01;
        1: bb[7:0] = 8'h03;
        2: bb[7:0] = 8'h81;
        3: bb[7:0] = 8'h83;
        4: bb[7:0] = 8'hB8 + 8'($urandom_range(0, 7));
        5: bb[7:0] = 8'hEA;
        default: ;
      endcase
      if ((bb[7:0] == 8'h81 || bb[7:0] == 8'h83) && $urandom_range(0, 3) != 0)
        bb[13:11] = 3'b000;
      model(bb, e, n, er);
      o_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
        sh = bb >> (8 * i);
        send_byte(sh[7:0], ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      if (er) begin
        check1($sformatf("rnd%0d.err", k), o_err, 1'b1);
        check1($sformatf("rnd%0d.no_valid", k), o_valid, 1'b0);
      end else begin
        check1($sformatf("rnd%0d.valid", k), o_valid, 1'b1);
        stall = int'($urandom_range(0, 2));
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check1($sformatf("rnd%0d.hold%0d", k, s), o_valid, 1'b1);
        end
        o_ready = 1'b1;
        check_res($sformatf("rnd%0d.fields", k), capture(), e);
        @(negedge clk);
        check1($sformatf("rnd%0d.valid_drop", k), o_valid, 1'b0);
        o_ready = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/x86_add_decoder.md
Name: x86_add_decoder

Overview:
- Byte-serial instruction decoder that sits in front of the datapath.
- Consumes raw x86 instruction bytes and assembles the decoded-field bundle the datapath consumes: sr1, sr2, isAddrbd, isO1Mem, isO2Mem, immSize, imm, disp, disp_size, op, far_jmp.
- Covers the ADD/MOV/far-JMP subset the datapath executes.
- Provides a valid/ready handshake on both the byte side and the decoded side.

Parameters:
- IMM_W, 48, immediate field width (holds ptr16:32).
- DISP_W, 32, displacement field width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- in_valid  in  1  byte available.
- in_byte  in  8  instruction byte.
- in_ready  out  1  byte accepted on clk edge when in_valid&&in_ready.
- o_valid  out  1  decoded bundle valid.
- o_ready  in  1  datapath accepts bundle.
- o_sr1  out  3  r/m or destination register.
- o_sr2  out  3  ModRM reg or second source.
- o_isAddrbd  out  1  absolute disp32 address (mod=00, rm=101).
- o_isO1Mem  out  1  operand 1 is memory.
- o_isO2Mem  out  1  operand 2 is memory.
- o_immSize  out  2  0 none, 1 imm8, 2 imm32, 3 ptr48.
- o_imm  out  IMM_W  immediate, little-endian assembled, upper bits zero.
- o_disp  out  DISP_W  displacement; disp8 in [7:0], upper bits zero (datapath sign-extends).
- o_disp_size  out  2  0 disp8, 1 disp32, 2 none.
- o_op  out  2  0 ADD, 2 MOV.
- o_far_jmp  out  1  far jump.
- o_len  out  4  instruction length in bytes.
- o_err  out  1  one-cycle pulse on unsupported encoding.

Behaviour:
- Reset: state OPC; all outputs 0, except o_disp_size=2 and in_ready=1.
- FSM states: OPC, MODRM, DISP, IMM, EMIT.
- OPC (in_ready=1), on the accepted byte:
  - 01/03/81/83 → MODRM.
  - B8+r → sr1=sr2=r, op=MOV, immSize=2 → IMM (4 bytes).
  - EA → far_jmp=1, immSize=3 → IMM (6 bytes).
  - Anything else → o_err pulse next cycle, remain OPC.
- MODRM, field mapping:
  - 01 (r/m += reg): sr1=rm, sr2=reg, o1m=(mod!=3).
  - 03 (reg += r/m): sr1=reg, sr2=rm, o2m=(mod!=3).
  - 81/83: reg field must be 0, else error; sr1=sr2=rm, o1m=(mod!=3), immSize 2/1.
- MODRM, addressing modes:
  - mod=00 rm=101 → isAddrbd=1, disp32.
  - mod=00 other rm → disp_size=2.
  - mod=01 → disp8.
  - mod=10 → disp32.
  - mod=11 → disp_size=2, no memory operand.
  - rm=100 with mod!=11 (SIB) → error, return to OPC.
- Next state after MODRM: DISP if a disp is present, else IMM if immSize!=0, else EMIT.
- Byte counters: a down-counter loads 1/4/6 on entering DISP/IMM. Bytes shift in LSB-first at the counter position. Exit when count reaches 1 on an accepted byte.
- Timing: o_valid rises the cycle after the last byte is accepted. Minimum latency is 2 cycles per 1-byte-field instruction, since every instruction has at least 2 bytes.
- EMIT: in_ready=0; o_valid=1; all fields held stable until o_valid&&o_ready. On that transfer: o_valid→0 the next cycle, field registers cleared (disp_size=2), state→OPC.
- No bubble is required beyond the EMIT handoff cycle.
- o_len counts accepted bytes of the instruction; maximum is 10 (81 modrm disp32 imm32).
- in_valid low mid-instruction: FSM waits, no timeout.
- Error: o_err=1 for exactly one cycle; no o_valid; partial fields discarded.
- rst asserted in any state, including EMIT with o_ready low, returns to the reset values the next cycle; the partial instruction is lost.

Decomposition:
- Shared package holds:
  - opcode constants (OPC_ADD_RM_R=0x01, OPC_ADD_R_RM=0x03, OPC_GRP1_IMM32=0x81, OPC_GRP1_IMM8=0x83, OPC_MOV_R_IMM=0xB8, OPC_JMP_FAR=0xEA);
  - OP_ADD/OP_MOV codes;
  - IMMSZ_* and DISPSZ_* encodings;
  - FSM state enum.
- One sub-module, x86_modrm_decode: combinational ModRM → {mod, reg, rm, disp_size, isAddrbd, mem, sib_err}.
- The FSM, byte counters and output register stay in the top.

Test Plan:
1. BB 78 56 34 12 → sr1=sr2=3, op=2, immSize=2, imm=0x12345678, o1m=0, disp_size=2, len=5, o_valid 1 cycle after 0x12.
2. 81 05 20 00 AB 89 A0 00 8F F8 → isAddrbd=1, o1m=1, disp=0x89AB0020, disp_size=1, immSize=2, imm=0xF88F00A0, op=0, len=10.
3. 83 46 80 05 → sr1=sr2=6, o1m=1, disp=0x80, disp_size=0, immSize=1, imm=0x05, len=4.
4. 03 3E then 01 D1 → first: sr1=7, sr2=6, o2m=1, disp_size=2, len=2; second: sr1=1, sr2=2, o1m=o2m=0, len=2.
5. EA 78 56 34 12 8F F8 with o_ready low 3 cycles → far_jmp=1, imm=0xF88F12345678, immSize=3, len=7; fields stable and in_ready=0 while stalled.
6. 0F, then 01 04, then rst mid-way through 81 05 20 → o_err pulses twice with no o_valid; after rst: outputs at reset values, in_ready=1, and the next BB... decodes cleanly.
